// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch bus: ALU flags and operands in, redirect handshake back to fetch.
// The pipeline/fetch side is the master; the branch resolve unit is the slave.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [2:0]      ex_funct3;
    logic            zero_flag;
    logic            sign_flag;
    logic            overflow_flag;
    logic            carry_flag;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_alu_result;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               zero_flag, sign_flag, overflow_flag, carry_flag,
               ex_pc, ex_imm, ex_alu_result, ex_pred_taken, ex_pred_pc,
               redirect_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               zero_flag, sign_flag, overflow_flag, carry_flag,
               ex_pc, ex_imm, ex_alu_result, ex_pred_taken, ex_pred_pc,
               redirect_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and JAL/JALR from ALU flags, detects mispredicts,
// drives a held redirect to fetch, then flushes younger stages for FLUSH_CYCLES cycles.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 stall_ex,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            redirect_valid_q;
    logic            flush_q;
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic            resolve;
    logic            cond_taken;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;

    // Flags come from A-B: signed less-than is sign^overflow, unsigned less-than is no carry-out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cond_taken = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond_taken = bus.zero_flag;
            3'b001:  cond_taken = ~bus.zero_flag;
            3'b100:  cond_taken = bus.sign_flag ^ bus.overflow_flag;
            3'b101:  cond_taken = ~(bus.sign_flag ^ bus.overflow_flag);
            3'b110:  cond_taken = ~bus.carry_flag;
            3'b111:  cond_taken = bus.carry_flag;
            default: cond_taken = 1'b0;
        endcase
    end

    assign resolve = (state_q == IDLE) && bus.ex_valid &&
                     (bus.ex_is_branch || bus.ex_is_jal || bus.ex_is_jalr);
    assign taken   = bus.ex_is_jalr || bus.ex_is_jal || cond_taken;
    assign target  = bus.ex_is_jalr ? {bus.ex_alu_result[XLEN-1:1], 1'b0}
                                    : bus.ex_pc + bus.ex_imm;
    assign next_pc = taken ? target : bus.ex_pc + XLEN'(4);
    assign mispredict = resolve &&
                        ((taken != bus.ex_pred_taken) ||
                         (taken && (target != bus.ex_pred_pc)));

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = next_pc;
                end
            end
            REDIRECT: begin
                // redirect_valid is always high in this state, so ready alone completes the handshake.
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q <= FC_W'(1)) state_d = IDLE;
                else                         flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= (state_d == REDIRECT);
            flush_q          <= (state_d != IDLE);
            if (resolve && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign flush_if_id        = flush_q;
    assign flush_id_ex        = flush_q;
    assign stall_ex           = flush_q;
    assign branch_count       = branch_cnt_q;
    assign mispredict_count   = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default build plus a CNT_W=2, FLUSH_CYCLES=0 build
// sharing the same EX stimulus; expected redirect PCs flow through a scoreboard queue.
module tb_branch_resolve_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus0 ();
    branch_resolve_unit_if #(.XLEN(XLEN)) bus1 ();

    logic        flush_if_id0, flush_id_ex0, stall_ex0;
    logic [15:0] branch_count0, mispredict_count0;
    logic        flush_if_id1, flush_id_ex1, stall_ex1;
    logic [1:0]  branch_count1, mispredict_count1;

    assign bus1.ex_valid      = bus0.ex_valid;
    assign bus1.ex_is_branch  = bus0.ex_is_branch;
    assign bus1.ex_is_jal     = bus0.ex_is_jal;
    assign bus1.ex_is_jalr    = bus0.ex_is_jalr;
    assign bus1.ex_funct3     = bus0.ex_funct3;
    assign bus1.zero_flag     = bus0.zero_flag;
    assign bus1.sign_flag     = bus0.sign_flag;
    assign bus1.overflow_flag = bus0.overflow_flag;
    assign bus1.carry_flag    = bus0.carry_flag;
    assign bus1.ex_pc         = bus0.ex_pc;
    assign bus1.ex_imm        = bus0.ex_imm;
    assign bus1.ex_alu_result = bus0.ex_alu_result;
    assign bus1.ex_pred_taken = bus0.ex_pred_taken;
    assign bus1.ex_pred_pc    = bus0.ex_pred_pc;

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .flush_if_id(flush_if_id0), .flush_id_ex(flush_id_ex0), .stall_ex(stall_ex0),
        .branch_count(branch_count0), .mispredict_count(mispredict_count0)
    );

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1), .stall_ex(stall_ex1),
        .branch_count(branch_count1), .mispredict_count(mispredict_count1)
    );

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus0.ex_valid      = 1'b0;
        bus0.ex_is_branch  = 1'b0;
        bus0.ex_is_jal     = 1'b0;
        bus0.ex_is_jalr    = 1'b0;
        bus0.ex_funct3     = 3'b000;
        bus0.zero_flag     = 1'b0;
        bus0.sign_flag     = 1'b0;
        bus0.overflow_flag = 1'b0;
        bus0.carry_flag    = 1'b0;
        bus0.ex_pc         = '0;
        bus0.ex_imm        = '0;
        bus0.ex_alu_result = '0;
        bus0.ex_pred_taken = 1'b0;
        bus0.ex_pred_pc    = '0;
    endtask

    // Present the prepared EX instruction for one cycle; a mispredict queues its corrected PC.
    task automatic fire(input logic exp_mis, input logic [XLEN-1:0] exp_pc);
        bus0.ex_valid = 1'b1;
        if (exp_mis) exp_q.push_back(exp_pc);
        step();
        clr();
    endtask

    task automatic expect_redirect(input string tag, input bit sel);
        int n = 0;
        while (!(sel ? bus1.redirect_valid : bus0.redirect_valid) && n < 8) begin
            step();
            n++;
        end
        check({tag, "_valid"}, sel ? bus1.redirect_valid : bus0.redirect_valid, 1);
        check({tag, "_queued"}, exp_q.size(), 1);
        if (exp_q.size() != 0)
            check({tag, "_pc"}, sel ? bus1.redirect_pc : bus0.redirect_pc, exp_q.pop_front());
    endtask

    // Handshake the held redirect on dut0, then measure the flush window length.
    task automatic complete0(input string tag);
        int n = 0;
        bus0.redirect_ready = 1'b1;
        step();
        bus0.redirect_ready = 1'b0;
        check({tag, "_valid_clr"}, bus0.redirect_valid, 0);
        while (flush_if_id0 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_flush_len"}, n, 2);
        check({tag, "_stall_end"}, stall_ex0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clr();
        bus0.redirect_ready = 1'b0;
        bus1.redirect_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus0.redirect_valid, 0);
        check("rst_pc", bus0.redirect_pc, 0);
        check("rst_flush", {flush_if_id0, flush_id_ex0, stall_ex0}, 0);
        check("rst_counts", {branch_count0, mispredict_count0}, 0);

        // BEQ taken, predicted correctly
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b000; bus0.zero_flag = 1'b1;
        bus0.ex_pc = 32'h100; bus0.ex_imm = 32'h20;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h120;
        fire(1'b0, '0);
        check("beq_valid", bus0.redirect_valid, 0);
        check("beq_flush", flush_if_id0, 0);
        check("beq_counts", {branch_count0, mispredict_count0}, {16'd1, 16'd0});

        // BLT not taken (sign^overflow=0) but predicted taken
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b100;
        bus0.sign_flag = 1'b1; bus0.overflow_flag = 1'b1;
        bus0.ex_pc = 32'h100; bus0.ex_imm = 32'h20;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h120;
        fire(1'b1, 32'h104);
        expect_redirect("blt", 1'b0);
        check("blt_flushes", {flush_if_id0, flush_id_ex0, stall_ex0}, 3'b111);
        // Wrong-path mispredicting branch while the redirect is held
        bus0.ex_valid = 1'b1; bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b001;
        bus0.zero_flag = 1'b0; bus0.ex_pc = 32'h800; bus0.ex_imm = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            check("blt_hold_valid", bus0.redirect_valid, 1);
            check("blt_hold_pc", bus0.redirect_pc, 32'h104);
        end
        clr();
        complete0("blt");
        check("blt_counts", {branch_count0, mispredict_count0}, {16'd2, 16'd1});

        // BLTU taken with negative offset, predicted not taken
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b110; bus0.carry_flag = 1'b0;
        bus0.ex_pc = 32'h200; bus0.ex_imm = 32'hFFFF_FFF0; bus0.ex_pred_taken = 1'b0;
        fire(1'b1, 32'h1F0);
        expect_redirect("bltu", 1'b0);
        complete0("bltu");

        // BGEU taken, same target
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b111; bus0.carry_flag = 1'b1;
        bus0.ex_pc = 32'h200; bus0.ex_imm = 32'hFFFF_FFF0; bus0.ex_pred_taken = 1'b0;
        fire(1'b1, 32'h1F0);
        expect_redirect("bgeu", 1'b0);
        complete0("bgeu");

        // JALR target gets bit0 cleared; wrong-path branch arrives during FLUSH
        bus0.ex_is_jalr = 1'b1; bus0.ex_alu_result = 32'h0000_1235;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h1230;
        fire(1'b1, 32'h1234);
        expect_redirect("jalr", 1'b0);
        bus0.redirect_ready = 1'b1;
        step();
        bus0.redirect_ready = 1'b0;
        check("jalr_in_flush", flush_if_id0, 1);
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b001; bus0.zero_flag = 1'b0;
        bus0.ex_pc = 32'h900; bus0.ex_imm = 32'h10;
        fire(1'b0, '0);
        step();
        check("jalr_flush_done", flush_if_id0, 0);
        check("jalr_wrongpath_valid", bus0.redirect_valid, 0);
        check("jalr_counts", {branch_count0, mispredict_count0}, {16'd5, 16'd4});

        // JAL predicted correctly, then JAL with a wrong predicted target
        bus0.ex_is_jal = 1'b1; bus0.ex_pc = 32'h300; bus0.ex_imm = 32'h40;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h340;
        fire(1'b0, '0);
        check("jal_ok_valid", bus0.redirect_valid, 0);
        bus0.ex_is_jal = 1'b1; bus0.ex_pc = 32'h300; bus0.ex_imm = 32'h40;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h344;
        fire(1'b1, 32'h340);
        expect_redirect("jal_tgt", 1'b0);
        complete0("jal_tgt");

        // Reserved funct3 011: never taken, still counted
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b011; bus0.zero_flag = 1'b1;
        bus0.carry_flag = 1'b1; bus0.ex_pc = 32'h600; bus0.ex_pred_taken = 1'b0;
        fire(1'b0, '0);
        check("f3_011_valid", bus0.redirect_valid, 0);

        // Fall-through PC wraps past the top of the address space
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b000; bus0.zero_flag = 1'b0;
        bus0.ex_pc = 32'hFFFF_FFFC; bus0.ex_imm = 32'h100;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h0000_00FC;
        fire(1'b1, 32'h0000_0000);
        expect_redirect("wrap", 1'b0);
        complete0("wrap");

        // JALR outranks a not-taken branch bit on the same instruction
        bus0.ex_is_jalr = 1'b1; bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b000;
        bus0.zero_flag = 1'b0; bus0.ex_alu_result = 32'h0000_4001;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h0000_4000;
        fire(1'b0, '0);
        check("prio_valid", bus0.redirect_valid, 0);
        check("prio_counts", {branch_count0, mispredict_count0}, {16'd10, 16'd6});

        // Reset while the redirect is held drops it
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b001; bus0.zero_flag = 1'b0;
        bus0.ex_pc = 32'h400; bus0.ex_imm = 32'h8; bus0.ex_pred_taken = 1'b0;
        fire(1'b1, 32'h408);
        expect_redirect("prerst", 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", bus0.redirect_valid, 0);
        check("midrst_pc", bus0.redirect_pc, 0);
        check("midrst_flush", {flush_if_id0, flush_id_ex0, stall_ex0}, 0);
        check("midrst_counts", {branch_count0, mispredict_count0}, 0);

        // BGE after reset: sign^overflow=1 so not taken, predicted taken
        bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b101;
        bus0.sign_flag = 1'b1; bus0.overflow_flag = 1'b0;
        bus0.ex_pc = 32'h700; bus0.ex_imm = 32'h40;
        bus0.ex_pred_taken = 1'b1; bus0.ex_pred_pc = 32'h740;
        fire(1'b1, 32'h704);
        expect_redirect("postrst", 1'b0);
        complete0("postrst");
        check("postrst_counts", {branch_count0, mispredict_count0}, {16'd1, 16'd1});

        // Second build: FLUSH_CYCLES=0 and 2-bit saturating counters, fetch always ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("sat_rst_counts", {branch_count1, mispredict_count1}, 0);
        for (int i = 0; i < 5; i++) begin
            bus0.ex_is_branch = 1'b1; bus0.ex_funct3 = 3'b001; bus0.zero_flag = 1'b0;
            bus0.ex_pc = 32'h500 + 32'(i) * 32'h10; bus0.ex_imm = 32'h20;
            bus0.ex_pred_taken = 1'b0;
            fire(1'b1, 32'h520 + 32'(i) * 32'h10);
            expect_redirect("nf", 1'b1);
            check("nf_flush_busy", flush_if_id1, 1);
            step();
            check("nf_idle_valid", bus1.redirect_valid, 0);
            check("nf_idle_flush", {flush_if_id1, flush_id_ex1, stall_ex1}, 0);
        end
        check("sat_mispredict", mispredict_count1, 2'd3);
        check("sat_branch", branch_count1, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
